// File: rtl/calc_input_seq.sv
`timescale 1ns/1ps
// Operand/opcode entry sequencer in front of the calculator ALU: debounces the
// NEXT/CLR buttons, walks the user through A, B and opcode, then latches the result.
module calc_input_seq #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    input  logic       BTN_NEXT,
    input  logic       BTN_CLR,
    input  logic [7:0] ALU_OUT_TMP,
    input  logic [3:0] FLAG_TMP,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] SEL_TMP,
    output logic [7:0] RESULT,
    output logic [3:0] FLAGS,
    output logic       OP_ERR,
    output logic       RESULT_VALID,
    output logic [2:0] STATE
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       next_p;
    logic       clr_p;

    assign btn_raw = {BTN_CLR, BTN_NEXT};
    assign next_p  = btn_pulse[0];
    assign clr_p   = btn_pulse[1];

    // Identical conditioning chain for each button: sync, debounce, rising-edge pulse.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          s1;
        logic          s2;
        logic          stable;
        logic          stable_d;
        logic [CW-1:0] cnt;

        // NOTE: the raw button is asynchronous, so it passes two flops before any
        // logic looks at it; all sequential state here uses non-blocking assignment.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                cnt      <= '0;
            end else begin
                s1       <= btn_raw[g];
                s2       <= s1;
                stable_d <= stable;
                if (s2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign btn_pulse[g] = stable & ~stable_d;
    end

    // Sequencer: clear wins over next; EXEC is a single unconditional capture cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= LOAD_A;
            A            <= '0;
            B            <= '0;
            SEL_TMP      <= '0;
            RESULT       <= '0;
            FLAGS        <= '0;
            OP_ERR       <= 1'b0;
            RESULT_VALID <= 1'b0;
        end else if (clr_p) begin
            state        <= LOAD_A;
            A            <= '0;
            B            <= '0;
            SEL_TMP      <= '0;
            RESULT       <= '0;
            FLAGS        <= '0;
            OP_ERR       <= 1'b0;
            RESULT_VALID <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (next_p) begin
                        A     <= SW;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (next_p) begin
                        B     <= SW;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (next_p) begin
                        SEL_TMP <= SW[3:0];
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    RESULT       <= ALU_OUT_TMP;
                    FLAGS        <= FLAG_TMP;
                    OP_ERR       <= (SEL_TMP > 4'hB);
                    RESULT_VALID <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (next_p) begin
                        RESULT_VALID <= 1'b0;
                        state        <= LOAD_A;
                    end
                end
                default: begin
                    RESULT_VALID <= 1'b0;
                    state        <= LOAD_A;
                end
            endcase
        end
    end

    assign STATE = state;

endmodule
